// File: rtl/vertical_strip_scan_ctrl_if.sv
// Interface bundling the image-RAM read port and the result stream of
// vertical_strip_scan_ctrl.
//   master : the scan controller (drives the RAM request and the result stream)
//   slave  : the environment (image RAM plus downstream feature buffer)
interface vertical_strip_scan_ctrl_if #(
    parameter int HEIGHT = 28,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 5
);
    // Image RAM read port: data returns exactly one cycle after mem_rd_en.
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [HEIGHT-1:0] mem_rdata;

    // Per-column result stream toward the feature buffer.
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_col;
    logic [CNT_W-1:0]  out_count;
    logic              out_last;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output out_valid,
        input  out_ready,
        output out_col,
        output out_count,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  out_valid,
        output out_ready,
        input  out_col,
        input  out_count,
        input  out_last
    );
endinterface

// File: rtl/vertical_strip_scan_ctrl.sv
// vertical_strip_scan_ctrl
// Walks the columns of one binarised frame held in a column-addressed image
// RAM. For each column it reads the HEIGHT-bit word, counts the transitions
// between adjacent rows and streams {column, count} downstream over a
// valid/ready handshake. One frame is processed per accepted start pulse.
//
// Per-column sequence: READ (issue RAM read) -> CAPTURE (count and register
// result) -> EMIT (hold result until accepted). With out_ready held high a
// column takes 3 cycles.
//
// Optional build macro VERTICAL_STRIP_TOTAL_EN adds a frame_total output that
// accumulates every accepted count of the current frame.
module vertical_strip_scan_ctrl #(
    parameter int HEIGHT = 28,
    parameter int WIDTH  = 28,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 5,
    parameter int TOT_W  = $clog2(WIDTH * (HEIGHT - 1) + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    vertical_strip_scan_ctrl_if.master bus
`ifdef VERTICAL_STRIP_TOTAL_EN
    ,
    output logic [TOT_W-1:0]          frame_total
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(WIDTH - 1);

    // Number of adjacent row pairs whose bits differ; covers all HEIGHT-1 pairs.
    function automatic logic [CNT_W-1:0] count_transitions(input logic [HEIGHT-1:0] col_bits);
        logic [HEIGHT-2:0] diff;
        logic [CNT_W-1:0]  sum;
        diff = col_bits[HEIGHT-2:0] ^ col_bits[HEIGHT-1:1];
        sum  = '0;
        for (int i = 0; i < HEIGHT - 1; i++) begin
            sum = sum + CNT_W'(diff[i]);
        end
        return sum;
    endfunction

    state_e            state_q,  state_d;
    logic [ADDR_W-1:0] col_q,    col_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              rd_en_q,  rd_en_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              valid_q,  valid_d;
    logic [ADDR_W-1:0] ocol_q,   ocol_d;
    logic [CNT_W-1:0]  ocount_q, ocount_d;
    logic              olast_q,  olast_d;
`ifdef VERTICAL_STRIP_TOTAL_EN
    logic [TOT_W-1:0]  total_q,  total_d;
`endif

    logic handshake;
    assign handshake = valid_q & bus.out_ready;

    // Next-state and next-output decode for the column sequencer.
    always_comb begin
        // NOTE: every _d starts as its _q so any branch that leaves a value
        // unassigned simply holds it; no path can infer a latch.
        state_d  = state_q;
        col_d    = col_q;
        busy_d   = busy_q;
        done_d   = done_q;
        rd_en_d  = rd_en_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        ocol_d   = ocol_q;
        ocount_d = ocount_q;
        olast_d  = olast_q;
`ifdef VERTICAL_STRIP_TOTAL_EN
        total_d  = total_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    col_d   = '0;
                    busy_d  = 1'b1;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
`ifdef VERTICAL_STRIP_TOTAL_EN
                    total_d = '0;
`endif
                end
            end

            // Read strobe is high for exactly this one cycle.
            ST_READ: begin
                rd_en_d = 1'b0;
                state_d = ST_CAPTURE;
            end

            // RAM data is valid now; register the column result.
            ST_CAPTURE: begin
                ocount_d = count_transitions(bus.mem_rdata);
                ocol_d   = col_q;
                olast_d  = (col_q == LAST_COL);
                valid_d  = 1'b1;
                state_d  = ST_EMIT;
            end

            // Result is frozen until the downstream side accepts it.
            ST_EMIT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    olast_d = 1'b0;
`ifdef VERTICAL_STRIP_TOTAL_EN
                    total_d = total_q + TOT_W'(ocount_q);
`endif
                    if (olast_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Only advanced below LAST_COL, so never wraps.
                        col_d   = col_q + ADDR_W'(1);
                        addr_d  = col_q + ADDR_W'(1);
                        rd_en_d = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                rd_en_d = 1'b0;
                valid_d = 1'b0;
                olast_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            ocol_q   <= '0;
            ocount_q <= '0;
            olast_q  <= 1'b0;
`ifdef VERTICAL_STRIP_TOTAL_EN
            total_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            col_q    <= col_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            ocol_q   <= ocol_d;
            ocount_q <= ocount_d;
            olast_q  <= olast_d;
`ifdef VERTICAL_STRIP_TOTAL_EN
            total_q  <= total_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_col   = ocol_q;
    assign bus.out_count = ocount_q;
    assign bus.out_last  = olast_q;
`ifdef VERTICAL_STRIP_TOTAL_EN
    assign frame_total   = total_q;
`endif

endmodule

// File: tb/tb_vertical_strip_scan_ctrl.sv
// Self-checking bench for vertical_strip_scan_ctrl: image RAM model with
// one-cycle read latency, a result monitor and directed frame scenarios.
module tb_vertical_strip_scan_ctrl;

    localparam int HEIGHT = 28;
    localparam int WIDTH  = 28;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 5;
    localparam int TOT_W  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef VERTICAL_STRIP_TOTAL_EN
    logic [TOT_W-1:0] frame_total;
`endif

    vertical_strip_scan_ctrl_if #(.HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    vertical_strip_scan_ctrl #(
        .HEIGHT(HEIGHT), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TOT_W(TOT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
`ifdef VERTICAL_STRIP_TOTAL_EN
        ,
        .frame_total(frame_total)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Image RAM model: one-cycle read latency.
    logic [HEIGHT-1:0] img [WIDTH];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.mem_rdata <= '0;
        else if (bus.mem_rd_en)
            bus.mem_rdata <= (int'(bus.mem_addr) < WIDTH) ? img[bus.mem_addr] : '1;
    end

    // Downstream ready: constant high or 50% random.
    bit ready_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records handshakes and done pulses, counts protocol violations.
    logic [ADDR_W-1:0] hs_col  [$];
    logic [CNT_W-1:0]  hs_cnt  [$];
    logic              hs_last [$];
    int                hs_edge [$];
    int                n_done      = 0;
    int                done_edge   = 0;
    int                stab_err    = 0;
    int                rd_emit_err = 0;
    int                addr_err    = 0;
    logic              prev_stall  = 1'b0;
    logic [ADDR_W-1:0] prev_col;
    logic [CNT_W-1:0]  prev_cnt;
    logic              prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!bus.out_valid || bus.out_col !== prev_col ||
                               bus.out_count !== prev_cnt || bus.out_last !== prev_last))
                stab_err <= stab_err + 1;
            if (bus.mem_rd_en && bus.out_valid)
                rd_emit_err <= rd_emit_err + 1;
            if (bus.mem_rd_en && int'(bus.mem_addr) >= WIDTH)
                addr_err <= addr_err + 1;
            if (bus.out_valid && bus.out_ready) begin
                hs_col.push_back(bus.out_col);
                hs_cnt.push_back(bus.out_count);
                hs_last.push_back(bus.out_last);
                hs_edge.push_back(cyc + 1);
            end
            if (done) begin
                n_done    <= n_done + 1;
                done_edge <= cyc + 1;
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_col   <= bus.out_col;
            prev_cnt   <= bus.out_count;
            prev_last  <= bus.out_last;
        end
    end

    // Reference transition count: compare each adjacent pair of rows.
    function automatic int ref_count(input logic [HEIGHT-1:0] v);
        int c = 0;
        for (int i = 0; i < HEIGHT - 1; i++)
            if (v[i] != v[i + 1]) c++;
        return c;
    endfunction

    task automatic fill_image(input int mode);
        for (int i = 0; i < WIDTH; i++)
            img[i] = (mode == 1) ? HEIGHT'($urandom) : '0;
    endtask

    task automatic start_frame(output int t0);
        @(posedge clk);
        #1;
        start = 1'b1;
        t0    = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int done_base, input int budget);
        int k = 0;
        while (n_done == done_base && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("done_seen_in_budget", 32'(n_done != done_base), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify_frame(input string name, input int base, input int done_base,
                                input int t0, input bit timing);
        int sum = 0;
        check({name, "_done_pulses"}, n_done - done_base, 1);
        check({name, "_n_results"}, hs_col.size() - base, WIDTH);
        check({name, "_busy_low"}, 32'(busy), 0);
        if (hs_col.size() >= base + WIDTH) begin
            for (int i = 0; i < WIDTH; i++) begin
                check($sformatf("%s_col%0d_index", name, i), hs_col[base + i], i);
                check($sformatf("%s_col%0d_count", name, i), hs_cnt[base + i], ref_count(img[i]));
                check($sformatf("%s_col%0d_last", name, i), hs_last[base + i], 32'(i == WIDTH - 1));
                sum += ref_count(img[i]);
            end
            if (timing) begin
                check({name, "_first_hs_edge"}, hs_edge[base] - t0, 3);
                check({name, "_last_hs_edge"}, hs_edge[base + WIDTH - 1] - t0, 84);
                check({name, "_done_edge"}, done_edge - t0, 85);
            end
        end
`ifdef VERTICAL_STRIP_TOTAL_EN
        check({name, "_frame_total"}, frame_total, sum);
`endif
        check({name, "_stable_while_stalled"}, stab_err, 0);
        check({name, "_no_read_in_emit"}, rd_emit_err, 0);
        check({name, "_addr_in_range"}, addr_err, 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_mem_rd_en"}, 32'(bus.mem_rd_en), 0);
        check({name, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({name, "_out_valid"}, 32'(bus.out_valid), 0);
        check({name, "_out_last"}, 32'(bus.out_last), 0);
        check({name, "_out_col"}, 32'(bus.out_col), 0);
        check({name, "_out_count"}, 32'(bus.out_count), 0);
`ifdef VERTICAL_STRIP_TOTAL_EN
        check({name, "_frame_total"}, 32'(frame_total), 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, dbase, k;

        // Reset state.
        fill_image(0);
        #12;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero image, ready held high.
        base = hs_col.size(); dbase = n_done;
        start_frame(t0);
        wait_done(dbase, 400);
        verify_frame("zero", base, dbase, t0, 1'b1);

        // Column 3 alternating, everything else zero.
        fill_image(0);
        img[3] = 28'hAAA_AAAA;
        base = hs_col.size(); dbase = n_done;
        start_frame(t0);
        wait_done(dbase, 400);
        verify_frame("alt", base, dbase, t0, 1'b1);
        if (hs_cnt.size() > base + 3) check("alt_col3_is_27", hs_cnt[base + 3], 27);

        // Single bit 0, single bit 13, all ones.
        fill_image(0);
        img[0] = 28'h000_0001;
        img[1] = 28'h000_2000;
        img[2] = 28'hFFF_FFFF;
        base = hs_col.size(); dbase = n_done;
        start_frame(t0);
        wait_done(dbase, 400);
        verify_frame("edge", base, dbase, t0, 1'b1);
        if (hs_cnt.size() > base + 2) begin
            check("edge_col0_is_1", hs_cnt[base + 0], 1);
            check("edge_col1_is_2", hs_cnt[base + 1], 2);
            check("edge_col2_is_0", hs_cnt[base + 2], 0);
        end

        // Random image with 50% random ready, two frames.
        ready_rand = 1'b1;
        for (int f = 0; f < 2; f++) begin
            fill_image(1);
            base = hs_col.size(); dbase = n_done;
            start_frame(t0);
            wait_done(dbase, 2000);
            verify_frame($sformatf("rand%0d", f), base, dbase, t0, 1'b0);
        end
        ready_rand = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during EMIT of column 10, then a full frame.
        fill_image(1);
        dbase = n_done;
        start_frame(t0);
        k = 0;
        while (!(bus.out_valid && bus.out_col == ADDR_W'(10)) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst_reached_col10", 32'(bus.out_valid && bus.out_col == ADDR_W'(10)), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        check("midrst_no_done", n_done - dbase, 0);
        check("midrst_idle", 32'(busy), 0);
        base = hs_col.size(); dbase = n_done;
        start_frame(t0);
        wait_done(dbase, 400);
        verify_frame("after_rst", base, dbase, t0, 1'b1);

        // Start pulses at column 5 and during DONE must be ignored.
        fill_image(1);
        base = hs_col.size(); dbase = n_done;
        start_frame(t0);
        k = 0;
        while (!(bus.out_valid && bus.out_col == ADDR_W'(5)) && k < 200) begin
            @(negedge clk);
            k++;
        end
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("ign_done_reached", 32'(done), 1);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        verify_frame("ignore", base, dbase, t0, 1'b1);
        check("ignore_no_restart_valid", 32'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
